// File: rtl/datapath_core_if.sv
// Control-unit to datapath bundle: bus source/load enables, external data, ALU
// command, and the datapath's bus, PC and status outputs.
interface datapath_core_if #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
);
    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [RW-1:0]     rd_idx;
    logic [RW-1:0]     wr_idx;
    logic              reg_out;
    logic              ba_out;
    logic              reg_in;
    logic              hi_in;
    logic              lo_in;
    logic              yin;
    logic              pc_in;
    logic              inc_pc;
    logic              hi_out;
    logic              lo_out;
    logic              zhi_out;
    logic              zlo_out;
    logic              pc_out;
    logic              ext_out;
    logic              c_out;
    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] c_data;
    logic              zin;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] pc_q;
    logic              busy;
    logic              done;
    logic              div0;
    logic              bus_err;

    modport master (
        output rd_idx, wr_idx, reg_out, ba_out, reg_in, hi_in, lo_in, yin, pc_in,
               inc_pc, hi_out, lo_out, zhi_out, zlo_out, pc_out, ext_out, c_out,
               ext_data, c_data, zin, alu_op,
        input  bus, pc_q, busy, done, div0, bus_err
    );

    modport slave (
        input  rd_idx, wr_idx, reg_out, ba_out, reg_in, hi_in, lo_in, yin, pc_in,
               inc_pc, hi_out, lo_out, zhi_out, zlo_out, pc_out, ext_out, c_out,
               ext_data, c_data, zin, alu_op,
        output bus, pc_q, busy, done, div0, bus_err
    );
endinterface

// File: rtl/datapath_core.sv
// Shared-bus CPU datapath: register file, PC, HI/LO, Y, Z and ALU with iterative signed MUL/DIV.
// Single-cycle ops land in Z at the sampling edge; MUL takes DATA_W cycles, DIV DATA_W+1; zin is ignored while busy.
module datapath_core #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input logic            clk,
    input logic            clr,
    datapath_core_if.slave dp
);
    localparam int CW = $clog2(DATA_W);

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND = 4'd2,  OP_OR   = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4,  OP_SHRA = 4'd5,  OP_SHL = 4'd6,  OP_ROR  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8,  OP_NEG  = 4'd9,  OP_NOT = 4'd10, OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12, OP_PASS = 4'd13;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    logic [DATA_W-1:0]   regs [NREGS];
    logic [DATA_W-1:0]   hi, lo, y, pc, bus;
    logic [2*DATA_W-1:0] z;
    logic                bus_err, busy, done, div0;
    logic [7:0]          srcs;
    state_t              state;

    assign srcs = {dp.reg_out, dp.hi_out, dp.lo_out, dp.zhi_out,
                   dp.zlo_out, dp.pc_out, dp.ext_out, dp.c_out};

    always_comb begin
        bus = '0;
        if (dp.reg_out)      bus = (dp.ba_out && dp.rd_idx == '0) ? '0 : regs[dp.rd_idx];
        else if (dp.hi_out)  bus = hi;
        else if (dp.lo_out)  bus = lo;
        else if (dp.zhi_out) bus = z[2*DATA_W-1:DATA_W];
        else if (dp.zlo_out) bus = z[DATA_W-1:0];
        else if (dp.pc_out)  bus = pc;
        else if (dp.ext_out) bus = dp.ext_data;
        else if (dp.c_out)   bus = dp.c_data;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            hi      <= '0;
            lo      <= '0;
            y       <= '0;
            pc      <= '0;
            bus_err <= 1'b0;
        end else begin
            if (dp.reg_in) regs[dp.wr_idx] <= bus;
            if (dp.hi_in)  hi <= bus;
            if (dp.lo_in)  lo <= bus;
            if (dp.yin)    y  <= bus;
            if (dp.pc_in)       pc <= bus;
            else if (dp.inc_pc) pc <= pc + DATA_W'(1);
            if ($countones(srcs) > 1) bus_err <= 1'b1;
        end
    end

    // Single-cycle ALU: A = Y, B = bus, shift amount from the low bits of B.
    logic [CW-1:0]       sh;
    logic [DATA_W:0]     add_r, sub_r;
    logic [2*DATA_W-1:0] rot_r, rot_l;
    logic [DATA_W-1:0]   alu_lo, alu_hi;

    assign sh    = bus[CW-1:0];
    assign add_r = {1'b0, y} + {1'b0, bus};
    assign sub_r = {1'b0, y} + {1'b0, ~bus} + {{DATA_W{1'b0}}, 1'b1};
    assign rot_r = {y, y} >> sh;
    assign rot_l = {y, y} << sh;

    always_comb begin
        alu_lo = '0;
        alu_hi = '0;
        case (dp.alu_op)
            OP_ADD:  begin alu_lo = add_r[DATA_W-1:0]; alu_hi = {{(DATA_W-1){1'b0}}, add_r[DATA_W]}; end
            OP_SUB:  begin alu_lo = sub_r[DATA_W-1:0]; alu_hi = {{(DATA_W-1){1'b0}}, sub_r[DATA_W]}; end
            OP_AND:  alu_lo = y & bus;
            OP_OR:   alu_lo = y | bus;
            OP_SHR:  alu_lo = y >> sh;
            OP_SHRA: alu_lo = $signed(y) >>> sh;
            OP_SHL:  alu_lo = y << sh;
            OP_ROR:  alu_lo = rot_r[DATA_W-1:0];
            OP_ROL:  alu_lo = rot_l[2*DATA_W-1:DATA_W];
            OP_NEG:  alu_lo = -bus;
            OP_NOT:  alu_lo = ~bus;
            OP_PASS: alu_lo = bus;
            default: alu_lo = '0;
        endcase
    end

    // Iterative unit: MUL adds shifted multiplicands, the MSB weight subtracts;
    // DIV works on magnitudes and restores signs in the FIX cycle.
    logic [CW-1:0]       cnt;
    logic [2*DATA_W-1:0] mcand, acc, partial, acc_nxt;
    logic [DATA_W-1:0]   mplier, quo, dvsr, a_save, mag_a, mag_b, q_fix, r_fix;
    logic [DATA_W:0]     rem, rem_sh, trial;
    logic                a_neg, q_neg, b_zero, is_div, last;

    assign last    = (cnt == CW'(DATA_W - 1));
    assign partial = mplier[0] ? mcand : '0;
    assign acc_nxt = last ? acc - partial : acc + partial;
    assign rem_sh  = {rem[DATA_W-1:0], quo[DATA_W-1]};
    assign trial   = rem_sh - {1'b0, dvsr};
    assign mag_a   = y[DATA_W-1] ? -y : y;
    assign mag_b   = bus[DATA_W-1] ? -bus : bus;
    assign q_fix   = q_neg ? -quo : quo;
    assign r_fix   = a_neg ? -rem[DATA_W-1:0] : rem[DATA_W-1:0];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            div0   <= 1'b0;
            z      <= '0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            a_save <= '0;
            a_neg  <= 1'b0;
            q_neg  <= 1'b0;
            b_zero <= 1'b0;
            is_div <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (dp.zin) begin
                        if (dp.alu_op == OP_MUL || dp.alu_op == OP_DIV) begin
                            state  <= S_RUN;
                            busy   <= 1'b1;
                            cnt    <= '0;
                            is_div <= (dp.alu_op == OP_DIV);
                            mcand  <= {{DATA_W{y[DATA_W-1]}}, y};
                            mplier <= bus;
                            acc    <= '0;
                            quo    <= mag_a;
                            dvsr   <= mag_b;
                            rem    <= '0;
                            a_save <= y;
                            a_neg  <= y[DATA_W-1];
                            q_neg  <= y[DATA_W-1] ^ bus[DATA_W-1];
                            b_zero <= (bus == '0);
                        end else begin
                            z <= {alu_hi, alu_lo};
                        end
                    end
                end
                S_RUN: begin
                    cnt    <= cnt + CW'(1);
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    acc    <= acc_nxt;
                    if (!trial[DATA_W]) begin
                        rem <= trial;
                        quo <= {quo[DATA_W-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh;
                        quo <= {quo[DATA_W-2:0], 1'b0};
                    end
                    if (last) begin
                        if (is_div) begin
                            state <= S_FIX;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            z     <= acc_nxt;
                        end
                    end
                end
                S_FIX: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (b_zero) begin
                        z    <= {a_save, {DATA_W{1'b1}}};
                        div0 <= 1'b1;
                    end else begin
                        z <= {r_fix, q_fix};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dp.bus     = bus;
    assign dp.pc_q    = pc;
    assign dp.busy    = busy;
    assign dp.done    = done;
    assign dp.div0    = div0;
    assign dp.bus_err = bus_err;
endmodule

// File: doc/datapath_core.md
# datapath_core

Parametrised successor to the single-width CPU datapath. It holds the general register file, PC, HI/LO, Y and the 2×DATA_W Z register, all on one shared bus. Compared with the fixed 32-bit datapath it adds three things: configurable width and register count, an iterative signed multiply/divide unit with a busy/done handshake, and sticky bus-contention detection. It sits between the control unit, which drives all enables, and the memory/IO subsystem, which supplies data through `ext_data` and `c_data`.

## Interface
- `DATA_W`, 32, datapath width; even, 8..64
- `NREGS`, 16, general register count; power of two, 2..16; RW = clog2(NREGS)
- `clk`  in  1  rising-edge clock
- `clr`  in  1  asynchronous, active-high reset
- `rd_idx`  in  RW  register driven on bus when `reg_out`
- `reg_out`  in  1  register-file bus source enable
- `ba_out`  in  1  R0 reads as zero when selected (base addressing)
- `wr_idx`  in  RW  register written from bus when `reg_in`
- `reg_in`  in  1  register write enable
- `hi_in`, `lo_in`, `yin`, `pc_in`  in  1 each  load from bus at clock edge
- `inc_pc`  in  1  PC += 1
- `hi_out`, `lo_out`, `zhi_out`, `zlo_out`, `pc_out`, `ext_out`, `c_out`  in  1 each  bus source enables
- `ext_data`, `c_data`  in  DATA_W  MDR/in-port data; sign-extended constant
- `zin`  in  1  start ALU op / load Z
- `alu_op`  in  4  operation code
- `bus`  out  DATA_W  current bus value
- `pc_q`  out  DATA_W  PC contents
- `busy`  out  1  iterative op in progress
- `done`  out  1  one-cycle pulse, iterative result written
- `div0`  out  1  sticky, divide by zero occurred
- `bus_err`  out  1  sticky, ≥2 bus sources enabled in one cycle

## Operation
- **Bus mux**
  - Sources in priority order: `reg_out`, `hi_out`, `lo_out`, `zhi_out`, `zlo_out`, `pc_out`, `ext_out`, `c_out`.
  - No source enabled → bus = 0.
  - Two or more sources enabled → highest priority wins, and `bus_err` sets at that clock edge.
- **Register file**
  - Bus value when `reg_out` is set: R[rd_idx], except 0 when rd_idx = 0 and `ba_out` = 1.
  - R0 is writable.
- **PC**
  - `pc_in` loads the bus; `inc_pc` adds 1 mod 2^DATA_W.
  - `pc_in` wins over `inc_pc`.
- **Single-cycle ops** (on `zin`; A = Y, B = bus; shift amount = B[clog2(DATA_W)-1:0]):
  - Codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR logical, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG B, 10 NOT B, 13 PASS B.
  - Z_lo = result.
  - Z_hi = {0…, carry-out} for ADD; {0…, no-borrow} for SUB; 0 for all others.
- **MUL (11)**
  - Signed A×B, 2·DATA_W-bit product, shift-add over DATA_W iterations.
  - Z_hi:Z_lo = product.
- **DIV (12)**
  - Signed restoring division, DATA_W iterations plus one sign-fixup cycle.
  - Z_lo = quotient (truncated toward zero); Z_hi = remainder, with the dividend's sign.
  - B = 0: Z_lo = all-ones, Z_hi = A, `div0` sets. Latency is unchanged.
- Operands for MUL/DIV are captured at the start edge; bus and Y may change afterwards.
- Codes 14 and 15: Z ← 0.
- **FSM states**
  - IDLE →(`zin` with MUL/DIV) RUN
  - RUN →(count = DATA_W-1, MUL) DONE
  - RUN →(count = DATA_W-1, DIV) FIX → DONE
  - DONE → IDLE
  - `busy` = 1 in RUN and FIX.
  - The Z write happens on entry to DONE; `done` = 1 in DONE.
- While `busy`:
  - `zin` is ignored.
  - Z holds its old value and may be read.
  - All other registers operate normally.

## Timing
- Every register updates on the rising edge of `clk`; `bus` is combinational from the enables.
- Single-cycle op: `zin` sampled at edge E → Z valid after E.
- MUL: start at edge E → Z written at edge E+DATA_W; `done` is high for the cycle after that edge.
- DIV: same as MUL but one cycle later (E+DATA_W+1).
- `zin` asserted in the DONE cycle starts a new op at that edge, so back-to-back ops work.
- `clr` (asynchronous, at any time, including mid-RUN) clears:
  - all registers and Z, and `pc_q` → 0;
  - `busy`, `done`, `div0`, `bus_err` → 0;
  - the FSM → IDLE.
- Sticky flags clear only on `clr`.

## Test plan
- **ADD with carry** (DATA_W = 32): R1 = 0xFFFFFFFF, Y ← R1, bus = 1 via `c_out`, ADD → Z_lo = 0, Z_hi = 1.
- **MUL**: Y = −3, B = 7 → `busy` for 32 cycles, `done` on the following cycle, Z = 0xFFFFFFFF_FFFFFFEB. `zin` pulsed mid-operation has no effect.
- **DIV**: Y = −7, B = 2 → Z_lo = −3, Z_hi = −1 after 33 cycles. B = 0 → Z_lo = 0xFFFFFFFF, Z_hi = −7, `div0` = 1.
- **Bus contention**: `hi_out` and `pc_out` in the same cycle → bus = HI, `bus_err` = 1 and still 1 ten cycles later. `ba_out` with rd_idx = 0 and R0 = 5 → bus = 0.
- **Reset mid-divide**: `clr` asserted at cycle 10 of DIV → `busy` = 0 and Z = 0 immediately; a new MUL afterwards completes correctly.
- **Parameter sweep**: DATA_W = 8, NREGS = 4.
  - ROL 0x81 by 1 → 0x03.
  - MUL −128×−1 → Z = 0x0080 after 8 cycles.
  - PC 0xFF + `inc_pc` → 0x00.
